// File: rtl/bubble_sort_ctrl.sv
// Bubble-sort engine: loads a burst, sorts it through an external less-than
// comparator (one compare per clock), then streams the values out smallest first.
module bubble_sort_ctrl #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic [WIDTH-1:0] cmp_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SORT, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [IW-1:0]    i_q, i_d;
  logic [IW-1:0]    p_q, p_d;
  logic [IW-1:0]    rd_q, rd_d;
  logic             swap_q, swap_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic [CW-1:0]    count_inc_s;
  logic [IW-1:0]    i_next_s;
  logic [IW-1:0]    last_i_s;
  logic [IW-1:0]    last_rd_s;
  logic             swap_now_s;
  logic             last_s;

  // n-2 is the final compare index and final pass number; n-1 is the last read slot
  assign count_inc_s = count_q + CW'(1);
  assign i_next_s    = i_q + IW'(1);
  assign last_i_s    = IW'(count_q - CW'(2));
  assign last_rd_s   = IW'(count_q - CW'(1));
  assign swap_now_s  = (cmp_out != {WIDTH{1'b0}});

  // Next-state, datapath updates and outputs
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    i_d       = i_q;
    p_d       = p_q;
    rd_d      = rd_q;
    swap_d    = swap_q;
    mem_d     = mem_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_data  = {WIDTH{1'b0}};
    out_last  = 1'b0;
    last_s    = 1'b0;
    cmp_a     = {WIDTH{1'b0}};
    cmp_b     = {WIDTH{1'b0}};

    case (state_q)
      IDLE, LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_d[count_q[IW-1:0]] = in_data;
          count_d = count_inc_s;
          // A full buffer terminates the burst regardless of in_last
          if (in_last || (count_inc_s == CW'(DEPTH))) begin
            i_d    = {IW{1'b0}};
            p_d    = {IW{1'b0}};
            rd_d   = {IW{1'b0}};
            swap_d = 1'b0;
            if (count_inc_s == CW'(1)) begin
              state_d = DRAIN;
            end else begin
              state_d = SORT;
            end
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = state_q;
        end
      end

      SORT: begin
        busy  = 1'b1;
        cmp_a = mem_q[i_next_s];
        cmp_b = mem_q[i_q];
        if (swap_now_s) begin
          mem_d[i_q]      = mem_q[i_next_s];
          mem_d[i_next_s] = mem_q[i_q];
          swap_d          = 1'b1;
        end else begin
          swap_d = swap_q;
        end
        if (i_q == last_i_s) begin
          // A pass without swaps means the data is already in order
          if (!(swap_q || swap_now_s) || (p_q == last_i_s)) begin
            state_d = DRAIN;
            rd_d    = {IW{1'b0}};
          end else begin
            i_d    = {IW{1'b0}};
            p_d    = p_q + IW'(1);
            swap_d = 1'b0;
          end
        end else begin
          i_d = i_next_s;
        end
      end

      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem_q[rd_q];
        last_s    = (rd_q == last_rd_s);
        out_last  = last_s;
        if (out_ready) begin
          if (last_s) begin
            state_d = IDLE;
            count_d = {CW{1'b0}};
          end else begin
            rd_d = rd_q + IW'(1);
          end
        end else begin
          rd_d = rd_q;
        end
      end

      default: begin
        state_d = IDLE;
        count_d = {CW{1'b0}};
      end
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= {CW{1'b0}};
      i_q     <= {IW{1'b0}};
      p_q     <= {IW{1'b0}};
      rd_q    <= {IW{1'b0}};
      swap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      i_q     <= i_d;
      p_q     <= p_d;
      rd_q    <= rd_d;
      swap_q  <= swap_d;
    end
  end

  // Sort buffer; contents are only visible in DRAIN, so it needs no reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Self-checking bench for bubble_sort_ctrl: directed table, hand-written corner
// sequences and randomized bursts checked against a plain sorted-queue model.
module tb_bubble_sort_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [4:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [4:0] cmp_a;
  logic [4:0] cmp_b;
  logic [4:0] cmp_out;
  logic       out_valid;
  logic [4:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;

  int n_vec  = 0;
  int n_fail = 0;

  int cmp_a_q[$];
  int cmp_b_q[$];

  typedef struct {
    int         n;
    bit         use_last;
    int         stall;
    logic [4:0] v[16];
    logic [4:0] exp_o[16];
    int         exp_sc;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  // The lab comparator: a < b, result on bit 0
  assign cmp_out = {4'b0000, (cmp_a < cmp_b)};

  bubble_sort_ctrl #(.WIDTH(5), .DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_out(cmp_out),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Bubble sort needs one pass per step the furthest-displaced value moves left,
  // plus one clean pass to detect completion, capped at n-1 passes.
  function automatic int ref_sort_cycles(input logic [4:0] v[16], input int n);
    int maxl, l, passes;
    if (n < 2) return 0;
    maxl = 0;
    for (int j = 0; j < n; j++) begin
      l = 0;
      for (int k = 0; k < j; k++) if (v[k] > v[j]) l++;
      if (l > maxl) maxl = l;
    end
    passes = (maxl + 1 > n - 1) ? n - 1 : maxl + 1;
    return passes * (n - 1);
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_cmp_a"}, cmp_a, 0);
    chk({tag, "_cmp_b"}, cmp_b, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic load(input logic [4:0] v[16], input int n, input bit use_last);
    for (int j = 0; j < n; j++) begin
      chk("load_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = v[j];
      in_last  = use_last && (j == n - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 5'd0;
  endtask

  task automatic run_burst(input logic [4:0] v[16], input int n, input bit use_last,
                           input int stall, input bit rnd, input logic [4:0] exp_o[16],
                           input int exp_sc);
    int sc, k, g;
    cmp_a_q.delete();
    cmp_b_q.delete();
    load(v, n, use_last);
    sc = 0;
    g  = 0;
    while (!out_valid && g < 400) begin
      chk("sort_in_ready", in_ready, 0);
      if (busy) begin
        sc++;
        cmp_a_q.push_back(int'(cmp_a));
        cmp_b_q.push_back(int'(cmp_b));
      end
      g++;
      @(negedge clk);
    end
    chk("sort_cycles", sc, exp_sc);
    chk("out_valid_rise", out_valid, 1);
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      chk("stall_data", out_data, exp_o[0]);
      chk("stall_valid", out_valid, 1);
      chk("stall_last", out_last, (n == 1) ? 1 : 0);
      @(negedge clk);
    end
    k = 0;
    g = 0;
    while (k < n && g < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, exp_o[k]);
      chk("drain_last", out_last, (k == n - 1) ? 1 : 0);
      chk("drain_busy", busy, 1);
      if (out_valid && out_ready) k++;
      g++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drain_count", k, n);
    check_idle_outputs("after");
  endtask

  initial begin
    logic [4:0] rv[16];
    logic [4:0] re[16];
    logic [4:0] sq[$];
    int rn, rstall;
    bit rlast;
    int ea[9] = '{3, 2, 1, 2, 1, 4, 1, 3, 4};
    int eb[9] = '{4, 4, 4, 3, 3, 3, 2, 2, 3};

    tbl[0] = '{n: 8, use_last: 1'b1, stall: 0,
               v: '{5'd5, 5'd3, 5'd31, 5'd0, 5'd17, 5'd3, 5'd9, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},
               exp_o: '{5'd0, 5'd1, 5'd3, 5'd3, 5'd5, 5'd9, 5'd17, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},
               exp_sc: 49};
    tbl[1] = '{n: 4, use_last: 1'b1, stall: 0,
               v: '{5'd1, 5'd2, 5'd3, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},
               exp_o: '{5'd1, 5'd2, 5'd3, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},
               exp_sc: 3};
    tbl[2] = '{n: 4, use_last: 1'b1, stall: 0,
               v: '{5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},
               exp_o: '{5'd1, 5'd2, 5'd3, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},
               exp_sc: 9};
    tbl[3] = '{n: 1, use_last: 1'b1, stall: 0,
               v: '{5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},
               exp_o: '{5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},
               exp_sc: 0};
    tbl[4] = '{n: 2, use_last: 1'b1, stall: 3,
               v: '{5'd2, 5'd6, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},
               exp_o: '{5'd2, 5'd6, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},
               exp_sc: 1};
    tbl[5] = '{n: 8, use_last: 1'b0, stall: 0,
               v: '{5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},
               exp_o: '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},
               exp_sc: 49};
    tbl[6] = '{n: 3, use_last: 1'b1, stall: 0,
               v: '{5'd3, 5'd3, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},
               exp_o: '{5'd3, 5'd3, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0},
               exp_sc: 2};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 5'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed table
    for (int t = 0; t < 7; t++) begin
      run_burst(tbl[t].v, tbl[t].n, tbl[t].use_last, tbl[t].stall, 1'b0,
                tbl[t].exp_o, tbl[t].exp_sc);
      if (t == 2) begin
        chk("cmp_seq_len", cmp_a_q.size(), 9);
        for (int j = 0; j < 9 && j < cmp_a_q.size(); j++) begin
          chk("cmp_seq_a", cmp_a_q[j], ea[j]);
          chk("cmp_seq_b", cmp_b_q[j], eb[j]);
        end
      end
      @(negedge clk);
    end

    // Reset while sorting [9,8,7] aborts the burst
    rv = '{5'd9, 5'd8, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    load(rv, 3, 1'b1);
    @(negedge clk);
    chk("mid_sort_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    reset = 1'b0;
    rv = '{5'd3, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    re = '{5'd1, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    run_burst(rv, 2, 1'b1, 0, 1'b0, re, 2 - 1);

    // Random bursts against the sorted-queue model
    for (int r = 0; r < 40; r++) begin
      rn     = $urandom_range(1, 8);
      rlast  = (rn < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      rstall = $urandom_range(0, 2);
      sq.delete();
      for (int j = 0; j < 16; j++) begin
        rv[j] = (j < rn) ? 5'($urandom_range(0, 31)) : 5'd0;
        if (j < rn) sq.push_back(rv[j]);
      end
      sq.sort();
      for (int j = 0; j < 16; j++) re[j] = (j < rn) ? sq[j] : 5'd0;
      run_burst(rv, rn, rlast, rstall, 1'b1, re, ref_sort_cycles(rv, rn));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
